pkt_mc_router: RTL and testbench
================================

# pkt_mc_router

Multicast successor of the SpiNNaker-style packet router. It matches each incoming packet key against a parametrised ternary routing table and forwards the packet to every channel set in the hit entry's route bitmask. Table misses are handled by a selectable mode, and a per-packet drop timeout clears packets stuck behind blocked channels. It sits between the packet input interface and the HSSL channel outputs, replacing the unicast router plus switch.

## Interface
Parameters:
- PACKET_BITS, 72, packet width
- KEY_LSB, 8, bit position of key LSB within packet
- KEY_BITS, 32, key width
- NUM_RREGS, 16, routing table entries, 1..64
- NUM_CHANNELS, 8, output channels, 1..32
- MISS_MODE, 0, 0 = drop on miss, 1 = send to default_route_in

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- reset  in  1  async active-high reset
- drop_wait_in  in  32  cycles without progress before remaining copies are dropped
- reg_key_in  in  KEY_BITS x NUM_RREGS  entry keys
- reg_mask_in  in  KEY_BITS x NUM_RREGS  entry masks
- reg_route_in  in  NUM_CHANNELS x NUM_RREGS  entry route bitmasks
- default_route_in  in  NUM_CHANNELS  miss route (MISS_MODE=1)
- pkt_in_data_in  in  PACKET_BITS  input packet
- pkt_in_vld_in  in  1  input valid
- pkt_in_rdy_out  out  1  input ready
- pkt_out_data_out  out  PACKET_BITS x NUM_CHANNELS  output packets
- pkt_out_vld_out  out  NUM_CHANNELS  output valids
- pkt_out_rdy_in  in  NUM_CHANNELS  output readies
- rt_cnt_out  out  3  count pulses: [0] timeout drop, [1] fully delivered, [2] miss drop

## Operation
- Lookup: `hit[i] = ((key & reg_mask_in[i]) == reg_key_in[i])`. The lowest-index hit wins.
- Route on hit is that entry's bitmask. On miss, route is 0 when MISS_MODE=0 and default_route_in when MISS_MODE=1.
- A zero route mask, from either path, is a miss drop.
- Lookup stage (LK):
  - Input handshake (vld && rdy) latches the packet and its computed route mask into LK.
  - `pkt_in_rdy_out = !lk_vld || lk_adv`.
  - `lk_adv = lk_vld && (zero_mask || out_free)`.
- Miss drop: LK advances with a zero mask, the packet is discarded, and rt_cnt_out[2] pulses for 1 cycle. The output stage is untouched.
- Output stage (OS):
  - Holds out_data and pending[NUM_CHANNELS-1:0].
  - `pkt_out_vld_out[c] = os_vld && pending[c]`.
  - `pkt_out_data_out[c] = out_data` for all c.
  - A handshake on channel c clears pending[c].
- Completion: when pending after the current handshakes is 0, OS is free (out_free) and rt_cnt_out[1] pulses.
- Drop timer:
  - wait_cnt loads drop_wait_in when a packet enters OS.
  - It reloads drop_wait_in on any cycle with at least one output handshake.
  - Otherwise it decrements while os_vld.
- Timeout drop: if wait_cnt==0 and pending is still nonzero after this cycle's handshakes, the remaining copies are dropped, OS is freed, and rt_cnt_out[0] pulses. Copies already delivered stay delivered.
- out_free = !os_vld, or completion, or timeout drop. OS reloads from LK in the same cycle.
- Only one of rt_cnt_out[1]/[0] asserts per OS packet. rt_cnt_out[2] may coincide with either.

## Timing
- Reset values:
  - pkt_out_vld_out all 0, pkt_out_data_out all 0, rt_cnt_out 0.
  - lk_vld 0, os_vld 0, pending 0, wait_cnt 0.
  - pkt_in_rdy_out evaluates to 1 in the reset state.
- Reset mid-operation discards LK and OS contents with no count pulses.
- Latency: input accepted at edge N puts the packet in LK after N. If OS is free, pkt_out_vld_out is high after edge N+1.
- Throughput: 1 packet/cycle when all targeted channels are ready every cycle.
- Handshake rules:
  - Output valid never drops without a handshake, except on timeout or reset.
  - Data is stable while valid is high.
- Table and default_route inputs are sampled only at input handshake. Later changes do not affect LK/OS packets.
- drop_wait_in=0: a packet not fully accepted on its first OS cycle is dropped at the end of that cycle.
- drop_wait_in=W with no progress: valid is visible for W+1 cycles, then dropped.
- All count pulses are single-cycle and registered, asserted the cycle after the causing edge.

## Test plan
- Unicast: entry0 key=0x10/mask=0xFFFFFFFF/route=0x04, all rdy=1, 10 back-to-back packets key 0x10.
  - Expect vld[2] only, 10 consecutive cycles.
  - Expect 10 rt_cnt_out[1] pulses.
  - Expect rdy never low.
- Priority/multicast: entry0 mask=0 route=0x81 and entry1 matching with route=0x02.
  - Expect entry0 used; ch0 and ch7 each receive the packet.
  - ch7 rdy delayed 3 cycles: ch0 completes first and ch7 holds valid.
  - Expect one [1] pulse after ch7 accepts.
- Miss: MISS_MODE=0 with no entry hit gives rt_cnt_out[2]=1 and no output valid. MISS_MODE=1 with default=0x10 gives delivery on ch4.
- Timeout: drop_wait_in=5, route=0x03, ch0 rdy=1, ch1 rdy=0.
  - Expect ch0 delivered.
  - Expect ch1 valid 6 cycles after the last progress, then cleared.
  - Expect rt_cnt_out[0]=1.
  - Expect the next queued packet presented the following cycle.
- Backpressure: all rdy=0, drop_wait_in=0xFFFFFFFF, 3 packets offered.
  - Expect 2 accepted (OS + LK), then pkt_in_rdy_out=0.
  - Raising rdy drains both in order.
- Reset mid-operation with LK and OS full: all valids 0 after reset, no count pulses, pkt_in_rdy_out=1, no stale packet after release.

Source files
------------

// File: rtl/pkt_mc_router.sv
// pkt_mc_router
//   Multicast packet router. Each incoming packet key is matched against a
//   ternary routing table (lowest matching entry wins). The packet is then
//   forwarded to every channel set in that entry's route bitmask. Misses are
//   dropped (MISS_MODE=0) or sent to default_route_in (MISS_MODE=1). A zero
//   route from either path is counted as a miss drop. A per-packet drop timer
//   discards the copies that are still undelivered when output progress
//   stalls.
//   Pipeline: LK (latched packet + route) -> OS (out_data + pending mask).
// Ports:
//   clk, reset           clock, async active-high reset
//   drop_wait_in         stall cycles tolerated before undelivered copies drop
//   reg_key_in/mask_in   per-entry key and mask
//   reg_route_in         per-entry route bitmask
//   default_route_in     miss route (MISS_MODE=1)
//   pkt_in_*             input packet valid/ready handshake
//   pkt_out_*            per-channel output packet valid/ready handshake
//   rt_cnt_out           1-cycle pulses: [0] timeout, [1] delivered, [2] miss

// Per-channel pending bit: one outstanding copy of the OS packet.
module pkt_mc_router_chan (
   input  logic clk,
   input  logic reset,
   input  logic load,        // new packet enters OS this cycle
   input  logic route_bit,   // this channel is targeted by the new packet
   input  logic release_os,  // OS packet finished (completed or timed out)
   input  logic os_vld,
   input  logic rdy,
   output logic vld,
   output logic hs,
   output logic pend_next    // pending after this cycle's handshake
);
   logic pending;

   assign vld       = os_vld && pending;
   assign hs        = vld && rdy;
   assign pend_next = pending && !hs;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)           pending <= 1'b0;
      else if (load)       pending <= route_bit;
      else if (release_os) pending <= 1'b0;
      else                 pending <= pend_next;
   end
endmodule

module pkt_mc_router #(
   parameter int PACKET_BITS  = 72,
   parameter int KEY_LSB      = 8,
   parameter int KEY_BITS     = 32,
   parameter int NUM_RREGS    = 16,
   parameter int NUM_CHANNELS = 8,
   parameter int MISS_MODE    = 0
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic [31:0]                               drop_wait_in,
   input  logic [NUM_RREGS-1:0][KEY_BITS-1:0]        reg_key_in,
   input  logic [NUM_RREGS-1:0][KEY_BITS-1:0]        reg_mask_in,
   input  logic [NUM_RREGS-1:0][NUM_CHANNELS-1:0]    reg_route_in,
   input  logic [NUM_CHANNELS-1:0]                   default_route_in,
   input  logic [PACKET_BITS-1:0]                    pkt_in_data_in,
   input  logic                                      pkt_in_vld_in,
   output logic                                      pkt_in_rdy_out,
   output logic [NUM_CHANNELS-1:0][PACKET_BITS-1:0]  pkt_out_data_out,
   output logic [NUM_CHANNELS-1:0]                   pkt_out_vld_out,
   input  logic [NUM_CHANNELS-1:0]                   pkt_out_rdy_in,
   output logic [2:0]                                rt_cnt_out
);
   typedef struct packed {
      logic [PACKET_BITS-1:0]  data;
      logic [NUM_CHANNELS-1:0] route;
   } lk_t;

   logic [KEY_BITS-1:0]     key;
   logic [NUM_CHANNELS-1:0] in_route;
   logic                    in_hs;
   logic                    lk_vld;
   lk_t                     lk_q;
   logic                    zero_mask, lk_adv, load_os, miss_drop;
   logic                    os_vld;
   logic [PACKET_BITS-1:0]  out_data;
   logic [31:0]             wait_cnt;
   logic [NUM_CHANNELS-1:0] os_hs, pend_next;
   logic                    complete, timeout, release_os, out_free;

   // Lookup: walk from the top so the lowest-index hit is the final winner.
   assign key = pkt_in_data_in[KEY_LSB +: KEY_BITS];
   always_comb begin
      in_route = (MISS_MODE != 0) ? default_route_in : '0;
      for (int i = NUM_RREGS-1; i >= 0; i--)
         if ((key & reg_mask_in[i]) == reg_key_in[i]) in_route = reg_route_in[i];
   end

   // Completion and timeout both look at pending after this cycle's handshakes.
   assign complete   = os_vld && (pend_next == '0);
   assign timeout    = os_vld && (wait_cnt == '0) && (pend_next != '0);
   assign release_os = complete || timeout;
   assign out_free   = !os_vld || release_os;

   assign zero_mask      = (lk_q.route == '0);
   assign lk_adv         = lk_vld && (zero_mask || out_free);
   assign load_os        = lk_vld && !zero_mask && out_free;
   assign miss_drop      = lk_adv && zero_mask;
   assign pkt_in_rdy_out = !lk_vld || lk_adv;
   assign in_hs          = pkt_in_vld_in && pkt_in_rdy_out;

   // Table/default route are captured here, so later edits never touch LK/OS.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lk_vld <= 1'b0;
         lk_q   <= '0;
      end else if (in_hs) begin
         lk_vld     <= 1'b1;
         lk_q.data  <= pkt_in_data_in;
         lk_q.route <= in_route;
      end else if (lk_adv) begin
         lk_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         os_vld   <= 1'b0;
         out_data <= '0;
      end else if (load_os) begin
         os_vld   <= 1'b1;
         out_data <= lk_q.data;
      end else if (release_os) begin
         os_vld   <= 1'b0;
      end
   end

   // Drop timer: any handshake counts as progress and restarts the wait.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                           wait_cnt <= '0;
      else if (load_os || (os_hs != '0))   wait_cnt <= drop_wait_in;
      else if (os_vld && wait_cnt != '0)   wait_cnt <= wait_cnt - 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rt_cnt_out <= '0;
      else       rt_cnt_out <= {miss_drop, complete, timeout};
   end

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      pkt_mc_router_chan u_ch (
         .clk        (clk),
         .reset      (reset),
         .load       (load_os),
         .route_bit  (lk_q.route[c]),
         .release_os (release_os),
         .os_vld     (os_vld),
         .rdy        (pkt_out_rdy_in[c]),
         .vld        (pkt_out_vld_out[c]),
         .hs         (os_hs[c]),
         .pend_next  (pend_next[c])
      );
      assign pkt_out_data_out[c] = out_data;
   end
endmodule

// File: tb/tb_pkt_mc_router.sv
// Bench for pkt_mc_router: directed scenario tasks plus a randomized run
// scored per channel against a table-lookup reference. Two instances share
// inputs: dut0 drops misses, dut1 sends misses to the default route.
module tb_pkt_mc_router;
   localparam int PB = 72, KB = 32, NR = 16, NC = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [31:0]               drop_wait = 32'd100;
   logic [NR-1:0][KB-1:0]     t_key, t_mask;
   logic [NR-1:0][NC-1:0]     t_route;
   logic [NC-1:0]             def_route = 8'h10;
   logic [PB-1:0]             in_data = '0;
   logic                      in_vld = 1'b0;
   logic [NC-1:0]             out_rdy = '0;
   logic                      rdy0, rdy1;
   logic [NC-1:0][PB-1:0]     data0, data1;
   logic [NC-1:0]             vld0, vld1;
   logic [2:0]                cnt0, cnt1;
   int n_cmp = 0, n_err = 0;
   logic [PB-1:0]             sq [NC][$];

   always #5 clk = ~clk;

   pkt_mc_router #(.MISS_MODE(0)) dut0 (
      .clk(clk), .reset(reset), .drop_wait_in(drop_wait),
      .reg_key_in(t_key), .reg_mask_in(t_mask), .reg_route_in(t_route),
      .default_route_in(def_route), .pkt_in_data_in(in_data),
      .pkt_in_vld_in(in_vld), .pkt_in_rdy_out(rdy0),
      .pkt_out_data_out(data0), .pkt_out_vld_out(vld0),
      .pkt_out_rdy_in(out_rdy), .rt_cnt_out(cnt0));

   pkt_mc_router #(.MISS_MODE(1)) dut1 (
      .clk(clk), .reset(reset), .drop_wait_in(drop_wait),
      .reg_key_in(t_key), .reg_mask_in(t_mask), .reg_route_in(t_route),
      .default_route_in(def_route), .pkt_in_data_in(in_data),
      .pkt_in_vld_in(in_vld), .pkt_in_rdy_out(rdy1),
      .pkt_out_data_out(data1), .pkt_out_vld_out(vld1),
      .pkt_out_rdy_in(out_rdy), .rt_cnt_out(cnt1));

   function automatic logic [PB-1:0] mk_pkt(input logic [KB-1:0] k);
      return {32'($urandom()), k, 8'($urandom())};
   endfunction

   // Reference lookup straight from the routing rules.
   function automatic logic [NC-1:0] ref_route(input logic [KB-1:0] k, input bit mm);
      for (int i = 0; i < NR; i++)
         if ((k & t_mask[i]) == t_key[i]) return t_route[i];
      return mm ? def_route : '0;
   endfunction

   task automatic do_reset();
      reset = 1'b1; in_vld = 1'b0; out_rdy = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Disabled entry: mask 0 with key 1 can never match.
   task automatic clear_table();
      for (int i = 0; i < NR; i++) begin
         t_key[i] = 32'h1; t_mask[i] = '0; t_route[i] = '0;
      end
      def_route = 8'h10;
   endtask

   task automatic test_reset();
      clear_table();
      reset = 1'b1; in_vld = 1'b0; out_rdy = '0;
      @(negedge clk);
      n_cmp++; if (vld0 !== 8'h00) begin n_err++; $display("FAIL rst_vld_in_reset: got %h want 00", vld0); end
      n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL rst_rdy_in_reset: got %b want 1", rdy0); end
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (vld0 !== 8'h00 || vld1 !== 8'h00) begin n_err++; $display("FAIL rst_vld: got %h/%h want 00", vld0, vld1); end
      n_cmp++; if (data0 !== '0) begin n_err++; $display("FAIL rst_data: got %h want 0", data0); end
      n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL rst_rdy: got %b want 1", rdy0); end
      n_cmp++; if (cnt0 !== 3'b000) begin n_err++; $display("FAIL rst_cnt: got %b want 000", cnt0); end
      @(posedge clk); #1;
   endtask

   task automatic test_unicast();
      logic [PB-1:0] sent[$];
      int nsent = 0, nvld = 0, first = -1, last = -1, npulse = 0, rdy_low = 0;
      do_reset(); clear_table();
      t_key[0] = 32'h10; t_mask[0] = '1; t_route[0] = 8'h04;
      out_rdy = '1; drop_wait = 32'd100;
      for (int c = 0; c < 16; c++) begin
         in_vld = (nsent < 10);
         in_data = mk_pkt(32'h10);
         @(negedge clk);
         if (in_vld) begin
            if (!rdy0) rdy_low++;
            else begin sent.push_back(in_data); nsent++; end
         end
         if (vld0 != '0) begin
            nvld++; if (first < 0) first = c; last = c;
            n_cmp++; if (vld0 !== 8'h04) begin n_err++; $display("FAIL uni_vld c%0d: got %h want 04", c, vld0); end
            n_cmp++;
            if (sent.size() == 0 || data0[2] !== sent[0]) begin
               n_err++; $display("FAIL uni_data c%0d: got %h want %h", c, data0[2], sent.size() > 0 ? sent[0] : '0);
            end
            if (sent.size() > 0) void'(sent.pop_front());
         end
         npulse += int'(cnt0[1]);
         @(posedge clk); #1;
      end
      in_vld = 1'b0;
      n_cmp++; if (nvld != 10) begin n_err++; $display("FAIL uni_nvld: got %0d want 10", nvld); end
      n_cmp++; if (first != 2 || last != 11) begin n_err++; $display("FAIL uni_window: got %0d..%0d want 2..11", first, last); end
      n_cmp++; if (npulse != 10) begin n_err++; $display("FAIL uni_pulses: got %0d want 10", npulse); end
      n_cmp++; if (rdy_low != 0) begin n_err++; $display("FAIL uni_rdy_low: got %0d want 0", rdy_low); end
   endtask

   task automatic test_priority();
      logic [PB-1:0] p;
      logic [NC-1:0] ev;
      do_reset(); clear_table();
      t_key[0] = 32'h0;  t_mask[0] = '0; t_route[0] = 8'h81;
      t_key[1] = 32'h55; t_mask[1] = '1; t_route[1] = 8'h02;
      p = mk_pkt(32'h55);
      for (int c = 0; c < 9; c++) begin
         in_vld = (c == 0); in_data = p;
         out_rdy = (c >= 5) ? 8'hFF : 8'h7F;
         @(negedge clk);
         ev = (c == 2) ? 8'h81 : (c >= 3 && c <= 5) ? 8'h80 : 8'h00;
         n_cmp++; if (vld0 !== ev) begin n_err++; $display("FAIL prio_vld c%0d: got %h want %h", c, vld0, ev); end
         n_cmp++; if (cnt0[1] !== (c == 6)) begin n_err++; $display("FAIL prio_done c%0d: got %b want %b", c, cnt0[1], c == 6); end
         if (c == 2 || c == 5) begin
            n_cmp++; if (data0[7] !== p || data0[0] !== p) begin n_err++; $display("FAIL prio_data c%0d: got %h want %h", c, data0[7], p); end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_miss();
      logic [PB-1:0] p, q;
      logic [2:0] e0, e1;
      do_reset(); clear_table();
      t_key[0] = 32'h10; t_mask[0] = '1; t_route[0] = 8'h04;
      t_key[1] = 32'h77; t_mask[1] = '1; t_route[1] = 8'h00;  // hit with empty route
      out_rdy = '1;
      p = mk_pkt(32'h99); q = mk_pkt(32'h77);
      for (int c = 0; c < 9; c++) begin
         in_vld = (c == 0 || c == 4); in_data = (c == 0) ? p : q;
         @(negedge clk);
         e0 = 3'b000; if (c == 2 || c == 6) e0[2] = 1'b1;
         e1 = 3'b000; if (c == 6) e1[2] = 1'b1; if (c == 3) e1[1] = 1'b1;
         n_cmp++; if (vld0 !== 8'h00 || cnt0 !== e0) begin n_err++; $display("FAIL miss0 c%0d: vld %h cnt %b want 00 %b", c, vld0, cnt0, e0); end
         n_cmp++; if (vld1 !== ((c == 2) ? 8'h10 : 8'h00) || cnt1 !== e1) begin n_err++; $display("FAIL miss1 c%0d: vld %h cnt %b want cnt %b", c, vld1, cnt1, e1); end
         if (c == 2) begin
            n_cmp++; if (data1[4] !== p) begin n_err++; $display("FAIL miss1_data: got %h want %h", data1[4], p); end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      localparam int W = 5;
      logic [PB-1:0] a, b;
      logic [NC-1:0] ev;
      logic [2:0] ec;
      int ch1_after = 0;
      do_reset(); clear_table();
      t_key[0] = 32'h20; t_mask[0] = '1; t_route[0] = 8'h03;
      t_key[1] = 32'h21; t_mask[1] = '1; t_route[1] = 8'h01;
      drop_wait = W; out_rdy = 8'h01;
      a = mk_pkt(32'h20); b = mk_pkt(32'h21);
      for (int c = 0; c < 12; c++) begin
         in_vld = (c <= 1); in_data = (c == 0) ? a : b;
         @(negedge clk);
         ev = (c == 2) ? 8'h03 : (c >= 3 && c <= W + 3) ? 8'h02 : (c == W + 4) ? 8'h01 : 8'h00;
         ec = 3'b000; if (c == W + 4) ec[0] = 1'b1; if (c == W + 5) ec[1] = 1'b1;
         if (c > 2 && vld0[1]) ch1_after++;
         n_cmp++; if (vld0 !== ev) begin n_err++; $display("FAIL to_vld c%0d: got %h want %h", c, vld0, ev); end
         n_cmp++; if (cnt0 !== ec) begin n_err++; $display("FAIL to_cnt c%0d: got %b want %b", c, cnt0, ec); end
         if (c == 2) begin
            n_cmp++; if (data0[0] !== a) begin n_err++; $display("FAIL to_data_a: got %h want %h", data0[0], a); end
         end
         if (c == W + 4) begin
            n_cmp++; if (data0[0] !== b) begin n_err++; $display("FAIL to_data_b: got %h want %h", data0[0], b); end
         end
         @(posedge clk); #1;
      end
      n_cmp++; if (ch1_after != W + 1) begin n_err++; $display("FAIL to_hold: got %0d want %0d", ch1_after, W + 1); end
      // zero wait: dropped at the end of the first OS cycle
      do_reset();
      drop_wait = 32'd0; out_rdy = 8'h01;
      for (int c = 0; c < 6; c++) begin
         in_vld = (c == 0); in_data = a;
         @(negedge clk);
         ev = (c == 2) ? 8'h03 : 8'h00;
         ec = (c == 3) ? 3'b001 : 3'b000;
         n_cmp++; if (vld0 !== ev || cnt0 !== ec) begin n_err++; $display("FAIL to0 c%0d: vld %h cnt %b want %h %b", c, vld0, cnt0, ev, ec); end
         @(posedge clk); #1;
      end
   endtask

   task automatic fill_blocked(output logic [PB-1:0] p0, output logic [PB-1:0] p1, output int nacc);
      logic [PB-1:0] pk[3];
      clear_table();
      t_key[0] = 32'h30; t_mask[0] = '1; t_route[0] = 8'h05;
      drop_wait = 32'hFFFF_FFFF; out_rdy = '0;
      for (int i = 0; i < 3; i++) pk[i] = mk_pkt(32'h30);
      nacc = 0;
      for (int c = 0; c < 6; c++) begin
         in_vld = 1'b1; in_data = pk[nacc < 3 ? nacc : 2];
         @(negedge clk);
         if (rdy0) nacc++;
         @(posedge clk); #1;
      end
      in_vld = 1'b0;
      p0 = pk[0]; p1 = pk[1];
   endtask

   task automatic test_backpressure();
      logic [PB-1:0] p0, p1;
      logic [PB-1:0] g0[$], g2[$];
      int nacc;
      do_reset();
      fill_blocked(p0, p1, nacc);
      @(negedge clk);
      n_cmp++; if (nacc != 2) begin n_err++; $display("FAIL bp_accepted: got %0d want 2", nacc); end
      n_cmp++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL bp_rdy: got %b want 0", rdy0); end
      n_cmp++; if (vld0 !== 8'h05 || data0[2] !== p0) begin n_err++; $display("FAIL bp_hold: vld %h data %h want 05 %h", vld0, data0[2], p0); end
      @(posedge clk); #1;
      out_rdy = '1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (vld0[0]) g0.push_back(data0[0]);
         if (vld0[2]) g2.push_back(data0[2]);
         @(posedge clk); #1;
      end
      n_cmp++; if (g0.size() != 2 || g0[0] !== p0 || g0[1] !== p1) begin n_err++; $display("FAIL bp_drain_ch0: got %0d pkts, first %h want %h", g0.size(), g0[0], p0); end
      n_cmp++; if (g2.size() != 2 || g2[0] !== p0 || g2[1] !== p1) begin n_err++; $display("FAIL bp_drain_ch2: got %0d pkts, first %h want %h", g2.size(), g2[0], p0); end
   endtask

   task automatic test_reset_mid();
      logic [PB-1:0] p0, p1;
      int nacc, stale = 0;
      do_reset();
      fill_blocked(p0, p1, nacc);
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (vld0 !== 8'h00 || cnt0 !== 3'b000) begin n_err++; $display("FAIL rmid_out: vld %h cnt %b want 00 000", vld0, cnt0); end
      n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL rmid_rdy: got %b want 1", rdy0); end
      @(posedge clk); #1 reset = 1'b0; out_rdy = '1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (vld0 != '0 || vld1 != '0 || cnt0 != '0 || cnt1 != '0 || !rdy0) stale++;
         @(posedge clk); #1;
      end
      n_cmp++; if (stale != 0) begin n_err++; $display("FAIL rmid_stale: got %0d cycles want 0", stale); end
   endtask

   task automatic test_random();
      logic [NC-1:0] r;
      logic [PB-1:0] w;
      int exp_miss = 0, exp_del = 0, obs_miss = 0, obs_del = 0, obs_to = 0, left = 0;
      do_reset();
      for (int i = 0; i < NR; i++) begin
         t_mask[i]  = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         t_key[i]   = 32'($urandom_range(0, 15)) & t_mask[i];
         t_route[i] = 8'($urandom_range(0, 255));
      end
      drop_wait = 32'd1000;
      for (int ch = 0; ch < NC; ch++) sq[ch].delete();
      for (int c = 0; c < 500; c++) begin
         if (c < 400) begin
            in_vld = 1'($urandom_range(0, 1));
            in_data = mk_pkt(32'($urandom_range(0, 31)));
            out_rdy = 8'($urandom());
         end else begin
            in_vld = 1'b0; out_rdy = '1;
         end
         @(negedge clk);
         if (in_vld && rdy0) begin
            r = ref_route(in_data[39:8], 1'b0);
            if (r == '0) exp_miss++;
            else begin
               exp_del++;
               for (int ch = 0; ch < NC; ch++) if (r[ch]) sq[ch].push_back(in_data);
            end
         end
         for (int ch = 0; ch < NC; ch++) begin
            if (vld0[ch] && out_rdy[ch]) begin
               n_cmp++;
               if (sq[ch].size() == 0) begin
                  n_err++; $display("FAIL rnd_extra ch%0d c%0d: got %h want none", ch, c, data0[ch]);
               end else begin
                  w = sq[ch].pop_front();
                  if (data0[ch] !== w) begin n_err++; $display("FAIL rnd_data ch%0d c%0d: got %h want %h", ch, c, data0[ch], w); end
               end
            end
         end
         obs_miss += int'(cnt0[2]); obs_del += int'(cnt0[1]); obs_to += int'(cnt0[0]);
         @(posedge clk); #1;
      end
      for (int ch = 0; ch < NC; ch++) left += sq[ch].size();
      n_cmp++; if (left != 0) begin n_err++; $display("FAIL rnd_undelivered: got %0d want 0", left); end
      n_cmp++; if (obs_miss != exp_miss) begin n_err++; $display("FAIL rnd_miss_cnt: got %0d want %0d", obs_miss, exp_miss); end
      n_cmp++; if (obs_del != exp_del) begin n_err++; $display("FAIL rnd_done_cnt: got %0d want %0d", obs_del, exp_del); end
      n_cmp++; if (obs_to != 0) begin n_err++; $display("FAIL rnd_timeout_cnt: got %0d want 0", obs_to); end
   endtask

   initial begin
      test_reset();
      test_unicast();
      test_priority();
      test_miss();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
